wb_burst_mem: RTL and testbench

//  Wishbone B4 registered-feedback slave memory; consumes cycles issued by wb_bfm_master on the far side of the bus.

---
 rtl/wb_burst_mem.sv | 220 ++++++++++++++++++++++
 tb/tb_wb_burst_mem.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_mem.sv
// Wishbone B4 registered-feedback burst memory slave (classic/const/incr, linear/wrap BTE).
// Define WB_BURST_MEM_ERR_EN to answer addresses >= MEM_SIZE with err instead of aliasing.
module wb_burst_mem #(
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int MEM_SIZE    = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int SB    = dw / 8;
  localparam int AB    = $clog2(SB);
  localparam int DEPTH = MEM_SIZE / SB;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_BURST = 2'd3;

  localparam logic [2:0] CTI_CONST = 3'b001;
  localparam logic [2:0] CTI_INCR  = 3'b010;
  localparam logic [2:0] CTI_END   = 3'b111;

  localparam logic [aw-1:0] LOW_M = aw'(SB - 1);

  logic [dw-1:0] mem_q [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic [dw-1:0] dat_q, dat_d;
  logic [aw-1:0] pred_q, pred_d;
  logic [2:0]    cti_q, cti_d;
  logic [1:0]    bte_q, bte_d;
`ifdef WB_BURST_MEM_ERR_EN
  logic          err_q, err_d;
`endif

  logic          req, hit, start, go_on, wr_en;
  logic [aw-1:0] adr_m, nxt_adr;
  logic [IW-1:0] wr_idx;

  function automatic logic [IW-1:0] idx_f(input logic [aw-1:0] a);
    return IW'((a >> AB) & aw'(DEPTH - 1));
  endfunction

  // Wrap inside the aligned block; linear bursts wrap at the memory size.
  function automatic logic [aw-1:0] next_f(
    input logic [aw-1:0] a,
    input logic [2:0]    cti,
    input logic [1:0]    bte
  );
    logic [aw-1:0] m;
    case (bte)
      2'b01:   m = aw'(4 * SB - 1);
      2'b10:   m = aw'(8 * SB - 1);
      2'b11:   m = aw'(16 * SB - 1);
      default: m = aw'(MEM_SIZE - 1);
    endcase
    if (cti == CTI_CONST) return a;
    return (a & ~m) | ((a + aw'(SB)) & m);
  endfunction

`ifdef WB_BURST_MEM_ERR_EN
  function automatic logic oor_f(input logic [aw-1:0] a);
    return 64'(a) >= 64'(MEM_SIZE);
  endfunction
`endif

  assign req     = wb_cyc_i & wb_stb_i;
  assign adr_m   = wb_adr_i & ~LOW_M;
  assign nxt_adr = next_f(adr_m, wb_cti_i, wb_bte_i);
  assign wr_idx  = idx_f(adr_m);
  assign hit     = (adr_m == pred_q) && (wb_bte_i == bte_q) &&
                   ((wb_cti_i == cti_q) || (wb_cti_i == CTI_END));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    dat_d   = '0;
    pred_d  = pred_q;
    cti_d   = cti_q;
    bte_d   = bte_q;
    wr_en   = 1'b0;
    start   = 1'b0;
    go_on   = 1'b0;
`ifdef WB_BURST_MEM_ERR_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            start = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (!req) state_d = S_IDLE;
        else if (cnt_q == 4'(WAIT_STATES - 1)) start = 1'b1;
        else cnt_d = cnt_q + 4'd1;
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (ack_q && req) begin
          wr_en = wb_we_i;
          go_on = (wb_cti_i == CTI_CONST) || (wb_cti_i == CTI_INCR);
        end
      end
      S_BURST: begin
        // A mismatching beat falls back to IDLE and is re-sampled as a first beat.
        state_d = S_IDLE;
        if (req && hit) begin
          wr_en = wb_we_i;
          go_on = (wb_cti_i != CTI_END);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_ACK;
      cnt_d   = '0;
      pred_d  = adr_m;
`ifdef WB_BURST_MEM_ERR_EN
      if (oor_f(adr_m)) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        dat_d = mem_q[idx_f(adr_m)];
      end
`else
      ack_d = 1'b1;
      dat_d = mem_q[idx_f(adr_m)];
`endif
    end

    if (go_on) begin
      state_d = S_BURST;
      pred_d  = nxt_adr;
      cti_d   = wb_cti_i;
      bte_d   = wb_bte_i;
`ifdef WB_BURST_MEM_ERR_EN
      if (oor_f(nxt_adr)) begin
        err_d   = 1'b1;
        state_d = S_ACK;
      end else begin
        ack_d = 1'b1;
        dat_d = mem_q[idx_f(nxt_adr)];
      end
`else
      ack_d = 1'b1;
      dat_d = mem_q[idx_f(nxt_adr)];
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      pred_q  <= '0;
      cti_q   <= '0;
      bte_q   <= '0;
`ifdef WB_BURST_MEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      pred_q  <= pred_d;
      cti_q   <= cti_d;
      bte_q   <= bte_d;
`ifdef WB_BURST_MEM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_en && !wb_rst_i) begin
      for (int b = 0; b < SB; b++) begin
        if (wb_sel_i[b]) mem_q[wr_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign wb_rty_o = 1'b0;
`ifdef WB_BURST_MEM_ERR_EN
  assign wb_err_o = err_q;
`else
  assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_burst_mem.sv
// Scoreboard bench for wb_burst_mem with WAIT_STATES=2, MEM_SIZE=1024.
// The WB_BURST_MEM_ERR_EN section runs only when that macro is defined.
module tb_wb_burst_mem;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic        wb_ack_o, wb_err_o, wb_rty_o;

  always #5 clk = ~clk;

  wb_burst_mem #(
    .aw(32), .dw(32), .MEM_SIZE(1024), .WAIT_STATES(WS)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] q_dat[$];
  logic        q_err[$];
  string       q_nm[$];

  logic [31:0] b_adr[8], b_dat[8];
  logic [2:0]  b_cti[8];
  logic [1:0]  b_bte[8];
  logic [3:0]  b_sel[8];
  logic        b_we[8];
  int          b_w[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic expect_rsp(input string nm, input logic [31:0] d,
                            input logic e);
    q_nm.push_back(nm);
    q_dat.push_back(d);
    q_err.push_back(e);
  endtask

  task automatic set_beat(input int i, input logic [31:0] adr,
                          input logic [2:0] cti, input logic [1:0] bte,
                          input logic we, input logic [31:0] dat,
                          input logic [3:0] sel);
    b_adr[i] = adr; b_cti[i] = cti; b_bte[i] = bte;
    b_we[i] = we; b_dat[i] = dat; b_sel[i] = sel;
  endtask

  // Master: hold each beat until ack/err is seen, then move on.
  task automatic run(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      wb_adr_i = b_adr[i]; wb_dat_i = b_dat[i]; wb_sel_i = b_sel[i];
      wb_we_i = b_we[i]; wb_cti_i = b_cti[i]; wb_bte_i = b_bte[i];
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      w = 0;
      @(negedge clk);
      while (!(wb_ack_o || wb_err_o) && w < 40) begin
        w++;
        @(negedge clk);
      end
      if (w >= 40) begin
        n_chk++;
        n_fail++;
        $display("FAIL beat%0d_timeout: waited %0d cycles, want ack", i, w);
      end
      b_w[i] = w;
      @(posedge clk);
      #1;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_cti_i = 3'b000; wb_bte_i = 2'b00;
  endtask

  task automatic wr1(input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel);
    set_beat(0, adr, 3'b000, 2'b00, 1'b1, dat, sel);
    run(1);
    chk("wr_lat", b_w[0], WS + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic rd1(input string nm, input logic [31:0] adr,
                     input logic [31:0] exp);
    expect_rsp(nm, exp, 1'b0);
    set_beat(0, adr, 3'b000, 2'b00, 1'b0, 32'h0, 4'hF);
    run(1);
    chk({nm, "_lat"}, b_w[0], WS + 1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    string       nm;
    logic [31:0] d;
    logic        e;
    if (wb_ack_o || wb_err_o) begin
      chk("ack_err_excl", {31'd0, wb_ack_o & wb_err_o}, 32'd0);
      if (!wb_we_i || wb_err_o) begin
        if (q_dat.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got dat 0x%08h, want no response",
                   wb_dat_o);
        end else begin
          nm = q_nm.pop_front();
          d  = q_dat.pop_front();
          e  = q_err.pop_front();
          chk({nm, "_err"}, {31'd0, wb_err_o}, {31'd0, e});
          chk(nm, wb_dat_o, d);
        end
      end
    end
  end

  initial begin
    int w;
    wb_rst_i = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = '0; wb_bte_i = '0;
    repeat (3) @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_err", {31'd0, wb_err_o}, 32'd0);
    chk("rst_rty", {31'd0, wb_rty_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    @(posedge clk);
    #1;

    wr1(32'h10, 32'hDEADBEEF, 4'hF);
    rd1("classic_rd", 32'h10, 32'hDEADBEEF);

    wr1(32'h20, 32'h11223344, 4'hF);
    wr1(32'h20, 32'hAABBCCDD, 4'h5);
    rd1("byte_lanes", 32'h20, 32'h11BB33DD);

    for (int i = 0; i < 4; i++) wr1(32'h30 + 32'(4 * i), 32'(i), 4'hF);

    expect_rsp("wrap4_b0", 32'd2, 1'b0);
    expect_rsp("wrap4_b1", 32'd3, 1'b0);
    expect_rsp("wrap4_b2", 32'd0, 1'b0);
    expect_rsp("wrap4_b3", 32'd1, 1'b0);
    set_beat(0, 32'h38, 3'b010, 2'b01, 1'b0, 32'h0, 4'hF);
    set_beat(1, 32'h3C, 3'b010, 2'b01, 1'b0, 32'h0, 4'hF);
    set_beat(2, 32'h30, 3'b010, 2'b01, 1'b0, 32'h0, 4'hF);
    set_beat(3, 32'h34, 3'b111, 2'b01, 1'b0, 32'h0, 4'hF);
    run(4);
    @(negedge clk);
    chk("wrap4_ack_after", {31'd0, wb_ack_o}, 32'd0);
    chk("wrap4_lat0", b_w[0], WS + 1);
    for (int i = 1; i < 4; i++) chk("wrap4_b2b", b_w[i], 0);
    @(posedge clk);
    #1;

    set_beat(0, 32'h40, 3'b001, 2'b00, 1'b1, 32'hC001, 4'hF);
    set_beat(1, 32'h40, 3'b001, 2'b00, 1'b1, 32'hC002, 4'hF);
    set_beat(2, 32'h40, 3'b001, 2'b00, 1'b1, 32'hC003, 4'hF);
    set_beat(3, 32'h40, 3'b111, 2'b00, 1'b1, 32'hC004, 4'hF);
    run(4);
    chk("const_lat0", b_w[0], WS + 1);
    chk("const_b3_lat", b_w[3], 0);
    @(posedge clk);
    #1;
    rd1("const_final", 32'h40, 32'hC004);

    for (int i = 0; i < 4; i++) wr1(32'h50 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);

    // Beat 2 skips 0x58: it still receives the predicted word, then re-issues.
    expect_rsp("mm_b0", 32'hA0, 1'b0);
    expect_rsp("mm_b1", 32'hA1, 1'b0);
    expect_rsp("mm_b2", 32'hA2, 1'b0);
    expect_rsp("mm_b3", 32'hA3, 1'b0);
    set_beat(0, 32'h50, 3'b010, 2'b00, 1'b0, 32'h0, 4'hF);
    set_beat(1, 32'h54, 3'b010, 2'b00, 1'b0, 32'h0, 4'hF);
    set_beat(2, 32'h5C, 3'b010, 2'b00, 1'b0, 32'h0, 4'hF);
    set_beat(3, 32'h5C, 3'b111, 2'b00, 1'b0, 32'h0, 4'hF);
    run(4);
    chk("mm_b1_lat", b_w[1], 0);
    chk("mm_gap", b_w[3], 1 + WS);
    @(posedge clk);
    #1;

    expect_rsp("rst_beat0", 32'd1, 1'b0);
    wb_adr_i = 32'h34; wb_cti_i = 3'b010; wb_bte_i = 2'b00;
    wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    w = 0;
    @(negedge clk);
    while (!wb_ack_o && w < 40) begin
      w++;
      @(negedge clk);
    end
    chk("rst_beat0_lat", w, WS + 1);
    wb_rst_i = 1'b1;
    @(posedge clk);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b000;
    @(negedge clk);
    chk("rst_mid_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_mid_err", {31'd0, wb_err_o}, 32'd0);
    chk("rst_mid_dat", wb_dat_o, 32'd0);
    @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    @(posedge clk);
    #1;
    rd1("rst_keep_10", 32'h10, 32'hDEADBEEF);
    rd1("rst_keep_40", 32'h40, 32'hC004);

`ifdef WB_BURST_MEM_ERR_EN
    wr1(32'h0, 32'h12345678, 4'hF);
    expect_rsp("err_rd", 32'h0, 1'b1);
    set_beat(0, 32'h400, 3'b000, 2'b00, 1'b0, 32'h0, 4'hF);
    run(1);
    chk("err_rd_lat", b_w[0], WS + 1);
    @(posedge clk);
    #1;
    expect_rsp("err_wr", 32'h0, 1'b1);
    set_beat(0, 32'h400, 3'b000, 2'b00, 1'b1, 32'h55, 4'hF);
    run(1);
    @(posedge clk);
    #1;
    rd1("err_no_alias", 32'h0, 32'h12345678);
`else
    wr1(32'h404, 32'hCAFEF00D, 4'hF);
    rd1("alias_rd", 32'h004, 32'hCAFEF00D);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q_dat.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
